// File: rtl/ntt_btf_sched_if.sv
// ntt_btf_sched_if: sequencer-side bundle toward coefficient RAM, twiddle ROM and butterfly
interface ntt_btf_sched_if #(
   parameter int LOGN = 8
);
   logic            start;
   logic            inv;
   logic            busy;
   logic            done;
   logic            rd_en;
   logic [LOGN-1:0] rd_addr_a;
   logic [LOGN-1:0] rd_addr_b;
   logic [LOGN:0]   tw_addr;
   logic [1:0]      btf_op;
   logic            btf_sel_dit;
   logic            btf_en_div2;
   logic            wr_en;
   logic [LOGN-1:0] wr_addr_a;
   logic [LOGN-1:0] wr_addr_b;
   logic            btf_fault;
   logic            fault_sticky;
   logic [7:0]      fault_cnt;
   modport master (
      input  start, inv, btf_fault,
      output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, btf_op, btf_sel_dit,
             btf_en_div2, wr_en, wr_addr_a, wr_addr_b, fault_sticky, fault_cnt
   );
   modport slave (
      output start, inv, btf_fault,
      input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, btf_op, btf_sel_dit,
             btf_en_div2, wr_en, wr_addr_a, wr_addr_b, fault_sticky, fault_cnt
   );
endinterface

// File: rtl/ntt_btf_sched.sv
// ntt_btf_sched: in-place radix-2 NTT/INTT butterfly sequencer with delayed write-back and fault accounting
module ntt_btf_sched #(
   parameter int LOGN    = 8,
   parameter int MEM_LAT = 1,
   parameter int BTF_LAT = 4,
   parameter int FLT_LAT = 1
) (
   input logic             clk,
   input logic             rst,
   ntt_btf_sched_if.master bus
);
   localparam int PIPE = MEM_LAT + BTF_LAT;
   localparam int FQ   = MEM_LAT + FLT_LAT;
   localparam int SW   = $clog2(LOGN);
   localparam int DW   = $clog2(PIPE + 1);
   localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
   localparam logic [LOGN-2:0] K_LAST = '1;
   localparam logic [DW-1:0]   D_LAST = DW'(PIPE - 1);
   localparam logic [LOGN-1:0] ONE    = LOGN'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
   state_t          state;
   logic [SW-1:0]   s, ns, lg;
   logic [LOGN-2:0] k, nk;
   logic [DW-1:0]   d;
   logic            inv_q, ni, issue_nxt;
   logic [LOGN-1:0] j, g, a_n, b_n, idx_n;
   logic [PIPE-1:0] vsr;
   logic [FQ-1:0]   fsr;
   logic [LOGN-1:0] asr [PIPE];
   logic [LOGN-1:0] bsr [PIPE];

   // Addresses of the pair issued next cycle; lg is log2 of the butterfly span
   always_comb begin
      ns = (state == DRAIN) ? s + 1'b1 : (state == IDLE) ? '0 : s;
      nk = (state == ISSUE) ? k + 1'b1 : '0;
      ni = (state == IDLE) ? bus.inv : inv_q;
      lg = ni ? ns : S_LAST - ns;
      j = {1'b0, nk} & ((ONE << lg) - ONE);
      g = {1'b0, nk} >> lg;
      a_n = ((g << lg) << 1) | j;
      b_n = a_n | (ONE << lg);
      idx_n = (ONE << (S_LAST - lg)) + g;
      issue_nxt = (state == IDLE && bus.start) || (state == ISSUE && k != K_LAST) ||
                  (state == DRAIN && d == D_LAST && s != S_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s <= '0;
         k <= '0;
         d <= '0;
         inv_q <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.rd_en <= 1'b0;
         bus.rd_addr_a <= '0;
         bus.rd_addr_b <= '0;
         bus.tw_addr <= '0;
         bus.fault_sticky <= 1'b0;
         bus.fault_cnt <= '0;
         vsr <= '0;
         fsr <= '0;
         for (int i = 0; i < PIPE; i++) begin
            asr[i] <= '0;
            bsr[i] <= '0;
         end
      end else begin
         bus.rd_en <= issue_nxt;
         if (issue_nxt) begin
            bus.rd_addr_a <= a_n;
            bus.rd_addr_b <= b_n;
            bus.tw_addr <= {ni, idx_n};
         end
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state <= ISSUE;
               inv_q <= bus.inv;
               s <= '0;
               k <= '0;
               bus.busy <= 1'b1;
            end
            ISSUE: begin
               k <= k + 1'b1;
               if (k == K_LAST) begin
                  state <= DRAIN;
                  d <= '0;
               end
            end
            DRAIN: begin
               d <= d + 1'b1;
               if (d == D_LAST) begin
                  state <= (s == S_LAST) ? FIN : ISSUE;
                  s <= (s == S_LAST) ? s : ns;
                  bus.busy <= (s != S_LAST);
                  bus.done <= (s == S_LAST);
               end
            end
            FIN: state <= IDLE;
         endcase
         // Valid taps: write strobe after PIPE, fault qualification after MEM_LAT+FLT_LAT
         vsr <= (vsr << 1) | PIPE'(bus.rd_en);
         fsr <= (fsr << 1) | FQ'(bus.rd_en);
         asr[0] <= bus.rd_addr_a;
         bsr[0] <= bus.rd_addr_b;
         for (int i = 1; i < PIPE; i++) begin
            asr[i] <= asr[i-1];
            bsr[i] <= bsr[i-1];
         end
         if (state == IDLE && bus.start) begin
            bus.fault_sticky <= 1'b0;
            bus.fault_cnt <= '0;
         end else if (fsr[FQ-1] && bus.btf_fault) begin
            bus.fault_sticky <= 1'b1;
            bus.fault_cnt <= (bus.fault_cnt == 8'hff) ? bus.fault_cnt : bus.fault_cnt + 1'b1;
         end
      end
   end

   assign bus.btf_op = 2'd0;
   assign bus.btf_sel_dit = bus.busy & ~inv_q;
   assign bus.btf_en_div2 = bus.busy & inv_q;
   assign bus.wr_en = vsr[PIPE-1];
   assign bus.wr_addr_a = asr[PIPE-1];
   assign bus.wr_addr_b = bsr[PIPE-1];
endmodule

// File: tb/tb_ntt_btf_sched.sv
// tb_ntt_btf_sched: table vectors, randomized runs against a schedule model, and corner sequences
module tb_ntt_btf_sched;
   localparam int LOGN = 3, MEM_LAT = 1, BTF_LAT = 4, FLT_LAT = 1;
   localparam int PIPE = MEM_LAT + BTF_LAT, N = 1 << LOGN, HALF = N / 2;
   localparam int PER = HALF + PIPE, LAST = LOGN * PER;

   typedef struct {bit inv; int a; int b; int tw;} vec_t;
   typedef struct {int a; int b; int tw;} pr_t;

   logic clk = 1'b0;
   logic rst;
   int checks = 0, failures = 0;
   int last_a = 0, last_b = 0, last_tw = 0, exp_cnt = 0;
   bit exp_sticky = 0;
   vec_t tab[24];
   pr_t got_q[$];

   ntt_btf_sched_if #(.LOGN(LOGN)) v();
   ntt_btf_sched_if #(.LOGN(8)) v8();

   ntt_btf_sched #(.LOGN(LOGN), .MEM_LAT(MEM_LAT), .BTF_LAT(BTF_LAT), .FLT_LAT(FLT_LAT))
      dut (.clk(clk), .rst(rst), .bus(v.master));
   ntt_btf_sched #(.LOGN(8), .MEM_LAT(MEM_LAT), .BTF_LAT(BTF_LAT), .FLT_LAT(FLT_LAT))
      dut8 (.clk(clk), .rst(rst), .bus(v8.master));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Pair issued in cycle t after an accepted start, from the transform definition
   function automatic bit model_pair(input int t, input bit iv, output int a, output int b, output int tw);
      int s, off, len, g;
      a = 0;
      b = 0;
      tw = 0;
      if (t < 1 || t > LAST) return 0;
      s = (t - 1) / PER;
      off = (t - 1) % PER;
      if (off >= HALF) return 0;
      len = iv ? (1 << s) : (N >> (s + 1));
      g = off / len;
      a = g * 2 * len + off % len;
      b = a + len;
      tw = (iv ? N + (1 << (LOGN - 1 - s)) : (1 << s)) + g;
      return 1;
   endfunction

   task automatic run(input bit iv, input int fmode, input int ign, output int done_at);
      int a, b, tw, wa, wb, wt, qa, qb, qt;
      bit rv, wv, f;
      logic [7:0] ctl;
      done_at = -1;
      got_q.delete();
      v.start = 1'b1;
      v.inv = iv;
      v.btf_fault = 1'b0;
      @(posedge clk); #1;
      exp_cnt = 0;
      exp_sticky = 0;
      for (int t = 1; t <= LAST + 3; t++) begin
         rv = model_pair(t, iv, a, b, tw);
         wv = model_pair(t - PIPE, iv, wa, wb, wt);
         if (rv) begin
            last_a = a;
            last_b = b;
            last_tw = tw;
         end
         ctl = {t <= LAST, t == LAST + 1, rv, wv, t <= LAST && !iv, t <= LAST && iv, 2'b00};
         chk($sformatf("ctl t=%0d", t), {v.busy, v.done, v.rd_en, v.wr_en, v.btf_sel_dit, v.btf_en_div2, v.btf_op}, ctl);
         chk($sformatf("rd_addr t=%0d", t), {v.rd_addr_a, v.rd_addr_b, v.tw_addr}, last_a * 128 + last_b * 16 + last_tw);
         if (wv) chk($sformatf("wr_addr t=%0d", t), {v.wr_addr_a, v.wr_addr_b}, wa * 8 + wb);
         chk($sformatf("fault t=%0d", t), {v.fault_sticky, v.fault_cnt}, exp_sticky * 256 + exp_cnt);
         if (v.done) done_at = t;
         if (v.rd_en) got_q.push_back('{int'(v.rd_addr_a), int'(v.rd_addr_b), int'(v.tw_addr)});
         v.start = (t == ign) || (t == LAST + 1);
         v.inv = 1'($urandom);
         f = (fmode == 1) ? ($urandom_range(0, 2) == 0) : (fmode == 2) ? (t >= 3 && t <= 5) : 1'b0;
         f = f || (fmode != 0 && t > LAST);
         v.btf_fault = f;
         if (f && model_pair(t - (MEM_LAT + FLT_LAT), iv, qa, qb, qt)) begin
            exp_sticky = 1;
            if (exp_cnt < 255) exp_cnt++;
         end
         @(posedge clk); #1;
      end
      v.start = 1'b0;
      v.btf_fault = 1'b0;
   endtask

   task automatic check_table(input bit iv);
      int n = 0;
      chk("pair_count", got_q.size(), HALF * LOGN);
      foreach (tab[i]) if (tab[i].inv == iv && n < got_q.size()) begin
         chk($sformatf("table%0d", i), got_q[n].a * 128 + got_q[n].b * 16 + got_q[n].tw,
             tab[i].a * 128 + tab[i].b * 16 + tab[i].tw);
         n++;
      end
   endtask

   initial begin
      int dc, n;
      bit bad;
      tab = '{'{0, 0, 4, 1}, '{0, 1, 5, 1}, '{0, 2, 6, 1}, '{0, 3, 7, 1},
              '{0, 0, 2, 2}, '{0, 1, 3, 2}, '{0, 4, 6, 3}, '{0, 5, 7, 3},
              '{0, 0, 1, 4}, '{0, 2, 3, 5}, '{0, 4, 5, 6}, '{0, 6, 7, 7},
              '{1, 0, 1, 12}, '{1, 2, 3, 13}, '{1, 4, 5, 14}, '{1, 6, 7, 15},
              '{1, 0, 2, 10}, '{1, 1, 3, 10}, '{1, 4, 6, 11}, '{1, 5, 7, 11},
              '{1, 0, 4, 9}, '{1, 1, 5, 9}, '{1, 2, 6, 9}, '{1, 3, 7, 9}};
      rst = 1'b1;
      {v.start, v.inv, v.btf_fault} = 3'b000;
      {v8.start, v8.inv, v8.btf_fault} = 3'b000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_state", {v.busy, v.done, v.rd_en, v.wr_en, v.btf_sel_dit, v.btf_en_div2, v.btf_op, v.rd_addr_a,
          v.rd_addr_b, v.tw_addr, v.wr_addr_a, v.wr_addr_b, v.fault_sticky, v.fault_cnt}, 0);

      run(1'b0, 2, 6, dc);
      chk("fwd_done_cycle", dc, 28);
      chk("three_faults", {v.fault_sticky, v.fault_cnt}, {1'b1, 8'd3});
      check_table(1'b0);
      run(1'b1, 0, -1, dc);
      chk("inv_done_cycle", dc, 28);
      check_table(1'b1);
      repeat (4) begin
         run(1'($urandom), 1, $urandom_range(1, LAST), dc);
         chk("rand_done_cycle", dc, 28);
      end

      v.start = 1'b1;
      v.inv = 1'b0;
      @(posedge clk); #1;
      v.start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      chk("busy_before_rst", v.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_reset_state", {v.busy, v.done, v.rd_en, v.wr_en, v.btf_sel_dit, v.btf_en_div2, v.btf_op, v.rd_addr_a,
          v.rd_addr_b, v.tw_addr, v.wr_addr_a, v.wr_addr_b, v.fault_sticky, v.fault_cnt}, 0);
      bad = 0;
      repeat (30) begin
         @(posedge clk); #1;
         bad = bad | v.wr_en | v.done | v.busy | v.rd_en;
      end
      chk("quiet_after_rst", bad, 1'b0);
      last_a = 0;
      last_b = 0;
      last_tw = 0;
      run(1'b0, 1, -1, dc);
      chk("post_rst_done_cycle", dc, 28);

      v8.btf_fault = 1'b1;
      v8.start = 1'b1;
      @(posedge clk); #1;
      v8.start = 1'b0;
      n = 1;
      while (!v8.done && n < 1500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("sat_done_cycle", n, 8 * (128 + PIPE) + 1);
      chk("sat_fault", {v8.fault_sticky, v8.fault_cnt}, {1'b1, 8'hff});
      v8.btf_fault = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
